ecc_secded_encoder_pipe: RTL
============================

Name: ecc_secded_encoder_pipe

Overview:
- Multi-lane Hamming SECDED encoder with valid/ready flow control. It generalises the single-lane, always-accepting registered encoder.
- Splits each input word into LANES independent lanes and computes SECDED check bits per lane internally, with no external encoder submodule.
- Sits between a write producer and cache/memory ports. A 2-entry skid buffer gives full throughput with a registered o_rdy.
- Also keeps a wrap-around count of words delivered downstream.

Parameters:
- LANE_W, 32, data bits per lane (4..64).
- LANES, 2, number of independent lanes (1..8).
- CNT_W, 16, width of the delivered-word counter.
- Derived localparam R: smallest r with 2^r >= LANE_W + r + 1. R = 6 for LANE_W = 32.
- Derived localparam CODE_W = R + 1, the check bits per lane. CODE_W = 7 at defaults.

Ports:
- i_clk, in, 1, sole clock; all logic on rising edge.
- i_rst, in, 1, reset, synchronous, active-high.
- i_data, in, LANES*LANE_W, input word; lane k = bits [k*LANE_W +: LANE_W].
- i_vld, in, 1, input valid.
- o_rdy, out, 1, input ready; registered.
- o_data, out, LANES*LANE_W, encoded data, lane-aligned with i_data.
- o_code, out, LANES*CODE_W, check bits; lane k = bits [k*CODE_W +: CODE_W].
- o_vld, out, 1, output valid.
- i_rdy, in, 1, downstream ready.
- o_cnt, out, CNT_W, count of output transfers (o_vld & i_rdy), wrapping modulo 2^CNT_W.

Behaviour:
- Encoding rule, per lane:
  - Data bits map to codeword positions 1..LANE_W+R that are not powers of two, in ascending order. data[0] goes to position 3, data[1] to 5, data[2] to 6, and so on.
  - code[j] for j < R = XOR of every data bit whose position has bit j set.
  - code[R] = XOR of all LANE_W data bits and code[R-1:0] (overall parity).
- Input transfer occurs on i_vld & o_rdy. Output transfer occurs on o_vld & i_rdy.
- Storage is an output register (OUT) plus a skid register (SKID). The FSM state is the occupancy:
  - EMPTY: o_vld = 0, o_rdy = 1. An accept loads OUT → ONE.
  - ONE: o_vld = 1, o_rdy = 1.
    - Accept with no output transfer: the new word goes to SKID → FULL.
    - Accept with an output transfer: the new word replaces OUT, state stays ONE.
    - Output transfer only → EMPTY.
  - FULL: o_vld = 1, o_rdy = 0.
    - An output transfer moves SKID to OUT → ONE.
    - No input is accepted in FULL.
- Check bits are computed combinationally on i_data and stored with the word. o_data/o_code are never recomputed from stored data.
- Latency: a word accepted at edge N appears on o_vld/o_data/o_code after edge N, provided OUT was empty or transferring at edge N.
- Throughput: 1 word/cycle while i_rdy = 1.
- Ordering is strict FIFO; no word is dropped or duplicated.
- o_vld, o_data and o_code stay stable while o_vld & !i_rdy.
- o_data/o_code in EMPTY hold their last value; a bench must not check them when o_vld = 0.
- o_cnt increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Reset values when i_rst = 1 at a clock edge:
  - state EMPTY, o_vld = 0, o_rdy = 1.
  - o_data = 0, o_code = 0, SKID = 0, o_cnt = 0.
- Reset mid-operation discards OUT and SKID contents without any output transfer.
- i_vld high during reset is ignored.
- The first accept can occur at the first edge with i_rst = 0.

Optional Feature:
- Macro: ECC_ERR_INJECT_EN.
- When defined, two ports are added: i_inj_arm (in, 1) and i_inj_mask (in, LANES*LANE_W).
  - A 1-cycle i_inj_arm captures i_inj_mask and sets an armed flag.
  - The next accepted word gets o_data = data ^ mask, with o_code computed on the unflipped data. The flag then clears (one-shot).
  - Arm and accept in the same cycle apply the new mask to that word.
  - Reset clears the flag and the mask.
- When undefined, the ports are absent and o_data always equals the accepted data.

Test Plan:
1. Reset, then accept i_data = {32'h0, 32'h1} with i_rdy = 1 → one cycle later o_vld = 1 and o_code = {7'h00, 7'h43}. Check lane 0 with data 32'h2 → 7'h45, 32'h4 → 7'h46, 32'h3 → 7'h06.
2. Stream 8 back-to-back words with i_rdy = 1 → o_rdy stays 1, 8 consecutive o_vld cycles in order, o_cnt = 8.
3. Hold i_rdy = 0 and drive i_vld continuously → 2 words accepted, o_rdy = 0 from the following cycle, o_data stable. Raise i_rdy → both delivered in order, then o_rdy = 1.
4. Random i_vld/i_rdy over 10k cycles against a reference model → no loss, duplication or reorder, codes match, and o_cnt equals the transfer count mod 2^16.
5. Assert i_rst while in FULL → next cycle o_vld = 0, o_rdy = 1, o_cnt = 0, and no stale word is emitted afterward.
6. With ECC_ERR_INJECT_EN, arm mask bit 0 and send 32'h0 on lane 0 → o_data lane 0 = 32'h1, o_code lane 0 = 7'h00. The following word is unflipped.

Source files
------------

// File: rtl/ecc_secded_encoder_pipe.sv
`default_nettype none
// ============================================================================
// Module  : ecc_secded_encoder_pipe
// Purpose : Multi-lane Hamming SECDED encoder with 2-entry skid buffer and
//           delivered-word counter. Optional macro: ECC_ERR_INJECT_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module ecc_secded_encoder_pipe #(
    parameter int LANE_W = 32,
    parameter int LANES  = 2,
    parameter int CNT_W  = 16,
    localparam int R = (LANE_W + 4 <= 8)  ? 3 :
                       (LANE_W + 5 <= 16) ? 4 :
                       (LANE_W + 6 <= 32) ? 5 :
                       (LANE_W + 7 <= 64) ? 6 : 7,
    localparam int CODE_W = R + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [LANES*LANE_W-1:0]  i_data,
    input  logic                     i_vld,
    output logic                     o_rdy,
    output logic [LANES*LANE_W-1:0]  o_data,
    output logic [LANES*CODE_W-1:0]  o_code,
    output logic                     o_vld,
    input  logic                     i_rdy,
`ifdef ECC_ERR_INJECT_EN
    input  logic                     i_inj_arm,
    input  logic [LANES*LANE_W-1:0]  i_inj_mask,
`endif
    output logic [CNT_W-1:0]         o_cnt
);

    localparam int DW = LANES * LANE_W;
    localparam int CW = LANES * CODE_W;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    // Codeword position of data bit idx: the idx-th non-power-of-two from 3 up.
    function automatic int data_pos(input int idx);
        int p;
        int n;
        p = 0;
        n = 0;
        for (int q = 3; q < 128; q++) begin
            if (p == 0 && (q & (q - 1)) != 0) begin
                if (n == idx) p = q;
                n = n + 1;
            end
        end
        return p;
    endfunction

    logic [CW-1:0]    w_code;
    logic [DW-1:0]    w_in_data;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_load_out_in;
    logic             w_load_skid;
    logic             w_load_out_skid;
    logic [1:0]       w_nxt;

    logic [1:0]       r_state;
    logic             r_vld;
    logic             r_rdy;
    logic [DW-1:0]    r_out_data;
    logic [CW-1:0]    r_out_code;
    logic [DW-1:0]    r_skid_data;
    logic [CW-1:0]    r_skid_code;
    logic [CNT_W-1:0] r_cnt;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [R-1:0] w_syn;
        always_comb begin
            w_syn = '0;
            for (int i = 0; i < LANE_W; i++) begin
                for (int j = 0; j < R; j++) begin
                    if (((data_pos(i) >> j) & 1) != 0)
                        w_syn[j] = w_syn[j] ^ i_data[k*LANE_W + i];
                end
            end
        end
        assign w_code[k*CODE_W +: CODE_W] =
            {(^i_data[k*LANE_W +: LANE_W]) ^ (^w_syn), w_syn};
    end

`ifdef ECC_ERR_INJECT_EN
    logic          r_armed;
    logic [DW-1:0] r_mask;
    logic [DW-1:0] w_flip;

    // A same-cycle arm overrides any mask captured earlier.
    assign w_flip    = i_inj_arm ? i_inj_mask : (r_armed ? r_mask : '0);
    assign w_in_data = i_data ^ w_flip;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_armed <= 1'b0;
            r_mask  <= '0;
        end else if (w_in_xfer) begin
            r_armed <= 1'b0;
        end else if (i_inj_arm) begin
            r_armed <= 1'b1;
            r_mask  <= i_inj_mask;
        end
    end
`else
    assign w_in_data = i_data;
`endif

    assign w_in_xfer  = i_vld & r_rdy;
    assign w_out_xfer = r_vld & i_rdy;

    assign w_load_out_in   = w_in_xfer & ((r_state == S_EMPTY) |
                                          ((r_state == S_ONE) & w_out_xfer));
    assign w_load_skid     = w_in_xfer & (r_state == S_ONE) & ~w_out_xfer;
    assign w_load_out_skid = (r_state == S_FULL) & w_out_xfer;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_in_xfer) w_nxt = S_ONE;
            S_ONE: begin
                if (w_in_xfer && !w_out_xfer)      w_nxt = S_FULL;
                else if (!w_in_xfer && w_out_xfer) w_nxt = S_EMPTY;
            end
            S_FULL:  if (w_out_xfer) w_nxt = S_ONE;
            default: w_nxt = S_EMPTY;
        endcase
    end

    // Ready/valid are flopped from the next occupancy so both leave as registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_EMPTY;
            r_vld       <= 1'b0;
            r_rdy       <= 1'b1;
            r_out_data  <= '0;
            r_out_code  <= '0;
            r_skid_data <= '0;
            r_skid_code <= '0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_nxt;
            r_vld   <= (w_nxt != S_EMPTY);
            r_rdy   <= (w_nxt != S_FULL);
            if (w_load_out_in) begin
                r_out_data <= w_in_data;
                r_out_code <= w_code;
            end else if (w_load_out_skid) begin
                r_out_data <= r_skid_data;
                r_out_code <= r_skid_code;
            end
            if (w_load_skid) begin
                r_skid_data <= w_in_data;
                r_skid_code <= w_code;
            end
            if (w_out_xfer) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_rdy  = r_rdy;
    assign o_vld  = r_vld;
    assign o_data = r_out_data;
    assign o_code = r_out_code;
    assign o_cnt  = r_cnt;

endmodule
`default_nettype wire
